// File: rtl/elevator_request_latch_if.sv
// Call-button / controller signal bundle for elevator_request_latch.
// slave is the latch side; master is the controller/test side.
interface elevator_request_latch_if;
    logic [3:0] call_btn;
    logic       motor_stop;
    logic [1:0] current_floor;
    logic       emergency_stop;
    logic [3:0] floor_req;
    logic [3:0] pending;
    logic       door_open;
    logic       serve_pulse;

    modport master (
        output call_btn, motor_stop, current_floor, emergency_stop,
        input  floor_req, pending, door_open, serve_pulse
    );

    modport slave (
        input  call_btn, motor_stop, current_floor, emergency_stop,
        output floor_req, pending, door_open, serve_pulse
    );
endinterface

// File: rtl/elevator_request_latch.sv
// Latches per-floor call presses, clears them on arrival and runs the door dwell timer.
// Optional button debounce is enabled by defining ELEVATOR_REQ_DEBOUNCE_EN.
module elevator_request_latch #(
    parameter int unsigned DOOR_CYCLES     = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    elevator_request_latch_if.slave        req_if
);
    localparam logic [7:0] DoorReload = 8'(DOOR_CYCLES - 1);

    typedef enum logic [1:0] {StWait, StDoor, StEmer} state_e;

    logic [3:0] s1_q, s2_q, s3_q;
    logic [3:0] level;
    logic [3:0] rise;
    logic [3:0] cur_mask;
    logic       cur_rise;
    logic       cur_pending;

    state_e     state_q;
    logic [7:0] timer_q;
    logic [3:0] pending_q;
    logic       door_q;
    logic       serve_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= 4'b0000;
            s2_q <= 4'b0000;
            s3_q <= 4'b0000;
        end else begin
            s1_q <= req_if.call_btn;
            s2_q <= s1_q;
            s3_q <= level;
        end
    end

`ifdef ELEVATOR_REQ_DEBOUNCE_EN
    localparam logic [7:0] DebCount = 8'(DEBOUNCE_CYCLES);

    logic [7:0] cnt_q [4];

    // Counter saturates at DebCount; the filtered level still follows s2 low immediately.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (reset || !s2_q[i]) begin
                cnt_q[i] <= 8'd0;
            end else if (cnt_q[i] < DebCount) begin
                cnt_q[i] <= cnt_q[i] + 8'd1;
            end
        end
    end

    always_comb begin
        level = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            level[i] = s2_q[i] && (cnt_q[i] >= DebCount);
        end
    end
`else
    assign level = s2_q;
`endif

    assign rise        = level & ~s3_q;
    assign cur_mask    = 4'b0001 << req_if.current_floor;
    assign cur_rise    = |(rise & cur_mask);
    assign cur_pending = |(pending_q & cur_mask);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StWait;
            timer_q   <= 8'd0;
            pending_q <= 4'b0000;
            door_q    <= 1'b0;
            serve_q   <= 1'b0;
        end else begin
            serve_q   <= 1'b0;
            pending_q <= pending_q | rise;
            case (state_q)
                StWait: begin
                    if (req_if.emergency_stop) begin
                        state_q <= StEmer;
                    end else if (req_if.motor_stop && cur_pending) begin
                        // A press at this floor in the serve cycle is absorbed by the clear.
                        pending_q <= (pending_q | rise) & ~cur_mask;
                        serve_q   <= 1'b1;
                        timer_q   <= DoorReload;
                        door_q    <= 1'b1;
                        state_q   <= StDoor;
                    end
                end
                StDoor: begin
                    if (req_if.emergency_stop) begin
                        door_q  <= 1'b0;
                        state_q <= StEmer;
                    end else if (cur_rise) begin
                        pending_q <= pending_q | (rise & ~cur_mask);
                        timer_q   <= DoorReload;
                    end else if (timer_q == 8'd0) begin
                        door_q  <= 1'b0;
                        state_q <= StWait;
                    end else begin
                        timer_q <= timer_q - 8'd1;
                    end
                end
                StEmer: begin
                    if (!req_if.emergency_stop) begin
                        state_q <= StWait;
                    end
                end
                default: begin
                    door_q  <= 1'b0;
                    state_q <= StWait;
                end
            endcase
        end
    end

    assign req_if.floor_req   = (state_q == StWait) ? pending_q : 4'b0000;
    assign req_if.pending     = pending_q;
    assign req_if.door_open   = door_q;
    assign req_if.serve_pulse = serve_q;
endmodule

// File: tb/tb_elevator_request_latch.sv
// Directed bench for elevator_request_latch: vector table for press/serve/dwell,
// hand sequences for re-arm, emergency, held buttons, reset and debounce.
module tb_elevator_request_latch;
`ifdef ELEVATOR_REQ_DEBOUNCE_EN
    localparam int DOOR = 16;
    localparam int HOLD = 5;  // shortest press that passes a 4-cycle debounce
    localparam int LAT  = 7;
`else
    localparam int DOOR = 8;
    localparam int HOLD = 1;
    localparam int LAT  = 3;
`endif

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad = 0;

    elevator_request_latch_if bus ();

    elevator_request_latch #(
        .DOOR_CYCLES    (DOOR),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .req_if(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int btn;
        int ms;
        int cf;
        int emer;
        int pend;
        int freq;
        int door;
        int serve;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int btn, input int ms, input int cf, input int emer);
        bus.call_btn       = 4'(btn);
        bus.motor_stop     = 1'(ms);
        bus.current_floor  = 2'(cf);
        bus.emergency_stop = 1'(emer);
        @(posedge clk);
        #1;
    endtask

    task automatic press(input int btn, input int ms, input int cf, input int emer, input int n);
        for (int i = 0; i < n; i++) step((i < HOLD) ? btn : 0, ms, cf, emer);
    endtask

    task automatic check_outs(input string tag, input int pend, input int freq, input int door,
                              input int serve);
        check({tag, ".pending"},   int'(bus.pending),     pend);
        check({tag, ".floor_req"}, int'(bus.floor_req),   freq);
        check({tag, ".door_open"}, int'(bus.door_open),   door);
        check({tag, ".serve"},     int'(bus.serve_pulse), serve);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dcnt;
        int leak;

        // Press on floor 2 from floor 0, then arrive at floor 2 and run the full dwell.
        for (int i = 0; i < LAT; i++)
            vecs.push_back('{(i < HOLD) ? 4 : 0, 1, 0, 0, (i == LAT - 1) ? 4 : 0,
                             (i == LAT - 1) ? 4 : 0, 0, 0});
        vecs.push_back('{0, 1, 2, 0, 0, 0, 1, 1});
        for (int i = 0; i < DOOR - 1; i++) vecs.push_back('{0, 1, 2, 0, 0, 0, 1, 0});
        vecs.push_back('{0, 1, 2, 0, 0, 0, 0, 0});

        reset = 1'b1;
        step(4'hF, 1, 0, 0);
        step(4'hF, 1, 0, 0);
        check_outs("reset", 0, 0, 0, 0);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].btn, vecs[i].ms, vecs[i].cf, vecs[i].emer);
            check_outs($sformatf("vec%0d", i), vecs[i].pend, vecs[i].freq, vecs[i].door,
                       vecs[i].serve);
        end

        // Re-arm: dwell re-press on floor 2 lands at dwell cycle LAT+2, plus a floor-3 press.
        press(4, 0, 2, 0, LAT);
        check("rearm.latch", int'(bus.pending), 4);
        step(0, 1, 2, 0);
        check("rearm.serve", int'(bus.serve_pulse), 1);
        dcnt = 1;
        leak = 0;
        for (int j = 1; j < 80; j++) begin
            step((j >= 3 && j < 3 + HOLD) ? 4'hC : 0, 1, 2, 0);
            if (!bus.door_open) break;
            dcnt++;
            leak |= int'(bus.floor_req);
        end
        check("rearm.dwell_len", dcnt, LAT + 2 + DOOR);
        check("rearm.req_masked", leak, 0);
        check("rearm.pending", int'(bus.pending), 8);
        check("rearm.floor_req", int'(bus.floor_req), 8);

        // Emergency mid-dwell with a press on floor 0, then release at floor 0.
        step(0, 1, 3, 0);
        check("emer.serve3", int'(bus.serve_pulse), 1);
        step(0, 1, 3, 0);
        step(0, 1, 3, 0);
        for (int i = 0; i < LAT; i++) begin
            step((i < HOLD) ? 1 : 0, 1, 3, 1);
            if (i == 0) check("emer.door_drop", int'(bus.door_open), 0);
        end
        check_outs("emer.hold", 1, 0, 0, 0);
        step(0, 1, 0, 0);
        check_outs("emer.release", 1, 1, 0, 0);
        step(0, 1, 0, 0);
        check_outs("emer.serve0", 0, 0, 1, 1);
        dcnt = 1;
        for (int j = 0; j < 80; j++) begin
            step(0, 1, 0, 0);
            if (!bus.door_open) break;
            dcnt++;
        end
        check("emer.dwell_len", dcnt, DOOR);

        // Held button latches once and does not re-latch until released.
        for (int i = 0; i < 20; i++) step(2, 0, 0, 0);
        check("hold.latch_once", int'(bus.pending), 2);
        step(2, 1, 1, 0);
        check_outs("hold.serve", 0, 0, 1, 1);
        for (int i = 0; i < DOOR + 4; i++) step(2, 1, 1, 0);
        check_outs("hold.no_relatch", 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
        press(2, 0, 1, 0, LAT);
        check("hold.repress", int'(bus.pending), 2);
        step(0, 1, 1, 0);
        check("hold.redwell", int'(bus.door_open), 1);
        step(0, 1, 1, 0);
        reset = 1'b1;
        step(0, 1, 1, 0);
        check_outs("reset.mid_dwell", 0, 0, 0, 0);
        reset = 1'b0;
        step(0, 1, 1, 0);
        check_outs("reset.after", 0, 0, 0, 0);

        // Simultaneous presses latch on the same edge.
        press(5, 0, 3, 0, LAT - 1);
        check("multi.early", int'(bus.pending), 0);
        step(0, 0, 3, 0);
        check("multi.latch", int'(bus.pending), 5);

        reset = 1'b1;
        step(0, 0, 3, 0);
        reset = 1'b0;
`ifdef ELEVATOR_REQ_DEBOUNCE_EN
        for (int i = 0; i < 12; i++) step((i < 3) ? 8 : 0, 0, 0, 0);
        check("deb.short_pulse", int'(bus.pending), 0);
        for (int i = 0; i < 6; i++) step(8, 0, 0, 0);
        check("deb.before_lat", int'(bus.pending), 0);
        step(0, 0, 0, 0);
        check("deb.latch", int'(bus.pending), 8);
`else
        step(8, 0, 0, 0);
        step(0, 0, 0, 0);
        check("sync.before_lat", int'(bus.pending), 0);
        step(0, 0, 0, 0);
        check("sync.latch", int'(bus.pending), 8);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/elevator_request_latch.md
Name: elevator_request_latch

Overview:
- Upstream stage of the elevator controller. Latches call-button presses per floor into a pending-request vector and drives the controller's `floor_req[3:0]`.
- Detects arrival at a requested floor from the controller's `motor_stop` and `current_floor`, then clears that request.
- Runs a door-open dwell timer after each arrival. `floor_req` is masked during the dwell so the controller stays idle.
- Respects `emergency_stop`.

Parameters:
- DOOR_CYCLES, 8: cycles `door_open` stays high per service; legal range 1..255.
- DEBOUNCE_CYCLES, 4: consecutive high cycles required per button when DEBOUNCE_EN is defined; legal range 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- call_btn  in  4  raw button levels, bit i = floor i; asynchronous to clk.
- motor_stop  in  1  from controller; high when the car is stationary.
- current_floor  in  2  from controller; the car's present floor.
- emergency_stop  in  1  same signal the controller receives.
- floor_req  out  4  to controller; pending requests, masked outside ST_WAIT.
- pending  out  4  latched request vector, unmasked, for indicator lamps.
- door_open  out  1  high during dwell.
- serve_pulse  out  1  one-cycle strobe on the cycle a request is cleared.

Behaviour:
- Interface: one clock `clk`; `reset` is synchronous and active-high.
- Reset values: `pending` = 0, `floor_req` = 0, `door_open` = 0, `serve_pulse` = 0. State = ST_WAIT, timer = 0, all synchroniser and edge flops = 0.
- Reset mid-dwell or mid-emergency returns to ST_WAIT with no pending requests.
- Input path, per bit:
  - 2-flop synchroniser s1→s2, then delay flop s3.
  - rise[i] = s2 & ~s3.
  - A button high before edge E1 gives `pending` = 1 after edge E3.
  - Holding a button latches once. Another request needs release and re-press.
- `pending[i]` is set on rise[i], except in the absorb cases below, and cleared only by a serve or by reset.
- `floor_req` = `pending` when state == ST_WAIT, else 4'b0000. This is combinational from registers with no added latency.
- FSM states: ST_WAIT, ST_DOOR, ST_EMER.
- ST_WAIT:
  - emergency_stop=1 → ST_EMER.
  - Else if motor_stop=1 and pending[current_floor]=1:
    - clear that bit;
    - `serve_pulse`=1 for the next cycle;
    - timer ← DOOR_CYCLES-1;
    - → ST_DOOR.
  - A rise on current_floor in the serve cycle is absorbed; clear wins.
- ST_DOOR:
  - `door_open`=1.
  - emergency_stop=1 → ST_EMER, and `door_open` drops next cycle.
  - Else if rise[current_floor]: timer ← DOOR_CYCLES-1. The dwell is re-armed and the bit is not latched.
  - Else if timer==0 → ST_WAIT.
  - Else timer ← timer-1.
  - `door_open` is high for exactly DOOR_CYCLES cycles absent re-arm.
  - Rises on other floors latch normally.
- ST_EMER:
  - `door_open`=0 and `floor_req`=0.
  - `pending` is retained and new presses still latch.
  - emergency_stop=0 → ST_WAIT.
  - A request at the current floor is then served on the following evaluation.
- Multiple simultaneous rises all latch in the same cycle.
- Only the `current_floor` bit is ever cleared, and at most one serve happens per cycle.
- Timer is 8 bits. DOOR_CYCLES=1 gives a single-cycle `door_open`.

Optional Feature:
- Macro: `ELEVATOR_REQ_DEBOUNCE_EN`.
- Defined:
  - Per-button 8-bit counter on s2.
  - Filtered level goes high after s2 has been high DEBOUNCE_CYCLES consecutive cycles.
  - Filtered level drops the cycle s2 goes low.
  - rise is taken on the filtered level.
  - Pulses shorter than DEBOUNCE_CYCLES never latch.
  - Press-to-`pending` latency = 3 + DEBOUNCE_CYCLES edges.
- Undefined: no counters; behaviour exactly as above.

Test Plan:
1. Reset, then press call_btn[2] for 1 cycle with current_floor=0 and motor_stop=1 → `pending`=4'b0100 after 3 edges; `floor_req`=4'b0100; `door_open`=0.
2. Set current_floor=2 with motor_stop=1 while pending[2]=1 → `serve_pulse` for 1 cycle; `pending`=0; `door_open` high exactly 8 cycles; `floor_req`=0 throughout the dwell.
3. In ST_DOOR at floor 2, re-press btn[2] at dwell cycle 5 and press btn[3] → dwell extends to 5+8 cycles; pending[2] stays 0; pending[3]=1; `floor_req`=4'b1000 after the dwell.
4. Assert emergency_stop mid-dwell and press btn[0] → `door_open`=0 next cycle; `floor_req`=0; `pending`=4'b0001. Release at floor 0 with motor_stop=1 → serve and an 8-cycle dwell follow.
5. Hold btn[1] high for 20 cycles → `pending[1]` sets once. Serve it → no re-latch until btn[1] is released and pressed again. Assert reset mid-dwell → all outputs 0 on the next cycle.
6. With ELEVATOR_REQ_DEBOUNCE_EN defined: a 3-cycle pulse on btn[3] → no latch. A 6-cycle pulse → `pending[3]`=1 after 3+4 edges.
